// File: rtl/cfir_tap_sequencer.sv
// cfir_tap_sequencer: circular-buffer delay line that streams TAPS taps newest-first to one shared MAC
// Ports: clk, rst (synchronous, active-low)
//        din/din_valid/din_ready                 sample input, accepted only in IDLE
//        tap_data/tap_idx/tap_valid/tap_ready    tap stream, one tap per accepted beat
//        tap_first/tap_last                      marks tap 0 and tap TAPS-1
//        busy                                    high while a burst is in progress
module cfir_tap_sequencer #(
    parameter int DATA_W = 16,
    parameter int TAPS   = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] tap_data,
    output logic [ADDR_W-1:0] tap_idx,
    output logic              tap_valid,
    input  logic              tap_ready,
    output logic              tap_first,
    output logic              tap_last,
    output logic              busy
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [TAPS];
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic [DATA_W-1:0] tap_data_q, tap_data_d;
    logic [ADDR_W-1:0] tap_idx_q, tap_idx_d;
    logic              tap_valid_q, tap_valid_d;
    logic              tap_first_q, tap_first_d;
    logic              tap_last_q, tap_last_d;
    logic              mem_we;
    logic [ADDR_W-1:0] rd_addr;

    // Tap k+1 lives k+1 slots behind the newest sample; ADDR_W wrap gives mod TAPS.
    assign rd_addr = base_q - k_q - ADDR_W'(1);

    always_comb begin
        state_d     = state_q;
        wp_d        = wp_q;
        base_d      = base_q;
        k_d         = k_q;
        tap_data_d  = tap_data_q;
        tap_idx_d   = tap_idx_q;
        tap_valid_d = tap_valid_q;
        tap_first_d = tap_first_q;
        tap_last_d  = tap_last_q;
        mem_we      = 1'b0;
        if (state_q == IDLE) begin
            if (din_valid) begin
                mem_we      = 1'b1;
                base_d      = wp_q;
                wp_d        = wp_q + ADDR_W'(1);
                k_d         = '0;
                tap_data_d  = din;
                tap_idx_d   = '0;
                tap_valid_d = 1'b1;
                tap_first_d = 1'b1;
                tap_last_d  = (TAPS == 1);
                state_d     = BURST;
            end
        end else if (tap_valid_q && tap_ready) begin
            if (k_q == ADDR_W'(TAPS - 1)) begin
                // Data and index keep their last values; only the qualifiers drop.
                tap_valid_d = 1'b0;
                tap_first_d = 1'b0;
                tap_last_d  = 1'b0;
                state_d     = IDLE;
            end else begin
                k_d         = k_q + ADDR_W'(1);
                tap_data_d  = mem_q[rd_addr];
                tap_idx_d   = k_q + ADDR_W'(1);
                tap_first_d = 1'b0;
                tap_last_d  = (k_q + ADDR_W'(1)) == ADDR_W'(TAPS - 1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wp_q        <= '0;
            base_q      <= '0;
            k_q         <= '0;
            tap_data_q  <= '0;
            tap_idx_q   <= '0;
            tap_valid_q <= 1'b0;
            tap_first_q <= 1'b0;
            tap_last_q  <= 1'b0;
            for (int i = 0; i < TAPS; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            wp_q        <= wp_d;
            base_q      <= base_d;
            k_q         <= k_d;
            tap_data_q  <= tap_data_d;
            tap_idx_q   <= tap_idx_d;
            tap_valid_q <= tap_valid_d;
            tap_first_q <= tap_first_d;
            tap_last_q  <= tap_last_d;
            if (mem_we) mem_q[wp_q] <= din;
        end
    end

    assign din_ready = rst & (state_q == IDLE);
    assign busy      = (state_q == BURST);
    assign tap_data  = tap_data_q;
    assign tap_idx   = tap_idx_q;
    assign tap_valid = tap_valid_q;
    assign tap_first = tap_first_q;
    assign tap_last  = tap_last_q;
endmodule
